// File: rtl/uio_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uio_arb_pkg
//  Brief    : Shared types and constants for the uio pad-bus arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package uio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_t;

    localparam logic [7:0] OE_DRIVE   = 8'hFF;
    localparam logic [7:0] OE_RELEASE = 8'h00;

    localparam int MAX_HOLD_DEFAULT   = 4;
    localparam int TURNAROUND_DEFAULT = 1;

endpackage
`default_nettype wire

// File: rtl/uio_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : uio_bus_arbiter_if
//  Brief    : Requester handshake and uio pad signals of the bus arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface uio_bus_arbiter_if;

    logic       ena;
    logic [1:0] req;
    logic [1:0] wr;
    logic [1:0] last;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic [1:0] gnt;
    logic       beat;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    // The master side models both the datapath requesters and the pad inputs.
    modport master (
        output ena, req, wr, last, wdata0, wdata1, uio_in,
        input  gnt, beat, rdata, rdata_valid, uio_out, uio_oe
    );

    modport slave (
        input  ena, req, wr, last, wdata0, wdata1, uio_in,
        output gnt, beat, rdata, rdata_valid, uio_out, uio_oe
    );

endinterface
`default_nettype wire

// File: rtl/uio_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : uio_rr_pick
//  Brief    : Combinational two-way round-robin picker, one-hot result.
//  Revision : 1.0  initial release
// ============================================================================
module uio_rr_pick (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] pick,
    output logic       any
);

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = prio ? 2'b10 : 2'b01;
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/uio_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uio_bus_arbiter
//  Brief    : Round-robin owner sequencer for the shared uio pad bus with
//             bounded bursts and a released-bus turnaround between owners.
//  Revision : 1.0  initial release
// ============================================================================
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int TURNAROUND = TURNAROUND_DEFAULT,
    parameter int MAX_HOLD   = MAX_HOLD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    uio_bus_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam int TC_W  = $clog2(TURNAROUND + 1);

    arb_state_t             state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   dir_q, dir_d;
    logic                   prio_q, prio_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [TC_W-1:0]        tcnt_q, tcnt_d;
    logic [1:0]             gnt_q, gnt_d;
    logic [7:0]             rdata_q, rdata_d;
    logic                   rdata_valid_q, rdata_valid_d;

    logic [1:0]             w_pick;
    logic                   w_any;
    logic                   w_beat;
    logic                   w_grant;

    uio_rr_pick u_pick (
        .req  (bus.req),
        .prio (prio_q),
        .pick (w_pick),
        .any  (w_any)
    );

    assign w_grant = (state_q == ST_GRANT);
    assign w_beat  = w_grant & bus.ena & bus.req[owner_q];

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        dir_d         = dir_q;
        prio_d        = prio_q;
        count_d       = count_q;
        tcnt_d        = tcnt_q;
        gnt_d         = gnt_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;

        // With ena low nothing advances; gnt and all counters simply hold.
        if (bus.ena) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (w_any) begin
                        state_d = ST_GRANT;
                        owner_d = w_pick[1];
                        dir_d   = bus.wr[w_pick[1]];
                        count_d = '0;
                        gnt_d   = w_pick;
                    end
                end
                ST_GRANT: begin
                    if (!bus.req[owner_q]) begin
                        state_d = ST_TURN;
                        tcnt_d  = '0;
                        gnt_d   = 2'b00;
                        prio_d  = ~owner_q;
                    end else begin
                        count_d = count_q + 1'b1;
                        if (!dir_q) begin
                            rdata_d       = bus.uio_in;
                            rdata_valid_d = 1'b1;
                        end
                        if (bus.last[owner_q] ||
                            ((count_q + 1'b1) == CNT_W'(MAX_HOLD))) begin
                            state_d = ST_TURN;
                            tcnt_d  = '0;
                            gnt_d   = 2'b00;
                            prio_d  = ~owner_q;
                        end
                    end
                end
                ST_TURN: begin
                    if (tcnt_q == TC_W'(TURNAROUND - 1)) begin
                        if (w_any) begin
                            state_d = ST_GRANT;
                            owner_d = w_pick[1];
                            dir_d   = bus.wr[w_pick[1]];
                            count_d = '0;
                            gnt_d   = w_pick;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            dir_q         <= 1'b0;
            prio_q        <= 1'b0;
            count_q       <= '0;
            tcnt_q        <= '0;
            gnt_q         <= 2'b00;
            rdata_q       <= 8'h00;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            dir_q         <= dir_d;
            prio_q        <= prio_d;
            count_q       <= count_d;
            tcnt_q        <= tcnt_d;
            gnt_q         <= gnt_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.beat        = w_beat;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.uio_out     = (w_grant && dir_q) ? (owner_q ? bus.wdata1 : bus.wdata0)
                                                : 8'h00;
    // Pads are released whenever the tile is paused, even mid-grant.
    assign bus.uio_oe      = (w_grant && dir_q && bus.ena) ? OE_DRIVE : OE_RELEASE;

endmodule
`default_nettype wire
